// File: rtl/key_schedule_ctrl.sv
// key_schedule_ctrl: sequences an external expansion-round unit to build
// Nr+1 round keys from a cipher key, and stores them for later readout.
// The round unit is issued one round at a time. It must answer within
// TIMEOUT cycles, otherwise the controller parks in ERR.
`timescale 1ns/1ps

module key_schedule_ctrl #(
   parameter int KEY_LENGTH = 128,
   parameter int Nr         = 10,
   parameter int TIMEOUT    = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  key_valid,
   output logic                  key_ready,
   input  logic [KEY_LENGTH-1:0] key_in,
   output logic                  rnd_valid,
   output logic [7:0]            rnd_idx,
   output logic [KEY_LENGTH-1:0] rnd_key,
   input  logic                  rnd_o_valid,
   input  logic [KEY_LENGTH-1:0] rnd_sched,
   input  logic [3:0]            rk_rd_addr,
   output logic [KEY_LENGTH-1:0] rk_rd_data,
   output logic                  sched_done,
   output logic                  busy,
   output logic                  err
);

   localparam int            TW     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
   localparam logic [3:0]    NR_L   = 4'(Nr);

   typedef enum logic [2:0] {IDLE, ISSUE, WAIT, DONE, ERR} state_t;

   state_t                state_q, state_d;
   logic [3:0]            round_q, round_d;
   logic [TW-1:0]         timer_q, timer_d;
   logic [KEY_LENGTH-1:0] rk_q [0:Nr];
   logic [KEY_LENGTH-1:0] rk_d [0:Nr];
   logic [KEY_LENGTH-1:0] rd_data_q, rd_data_d;
   logic [3:0]            prev_idx;

   // Index of the key fed to the round unit; only meaningful while round >= 1.
   assign prev_idx   = round_q - 4'd1;
   assign rk_rd_data = rd_data_q;

   // Next-state logic, round-key updates and Moore outputs of the FSM.
   always_comb begin
      // NOTE: every combinational output gets a default first, so no path leaves one unassigned and no latch is inferred.
      state_d    = state_q;
      round_d    = round_q;
      timer_d    = timer_q;
      rk_d       = rk_q;
      key_ready  = 1'b0;
      rnd_valid  = 1'b0;
      rnd_idx    = 8'd0;
      rnd_key    = '0;
      sched_done = 1'b0;
      busy       = 1'b0;
      err        = 1'b0;

      case (state_q)
         IDLE, DONE, ERR: begin
            key_ready  = 1'b1;
            sched_done = (state_q == DONE);
            err        = (state_q == ERR);
            if (key_valid) begin
               rk_d[0] = key_in;
               round_d = 4'd1;
               timer_d = '0;
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            busy      = 1'b1;
            rnd_valid = 1'b1;
            rnd_idx   = {4'd0, round_q};
            rnd_key   = rk_q[prev_idx];
            timer_d   = '0;
            state_d   = WAIT;
         end
         WAIT: begin
            busy    = 1'b1;
            rnd_idx = {4'd0, round_q};
            rnd_key = rk_q[prev_idx];
            if (rnd_o_valid) begin
               rk_d[round_q] = rnd_sched;
               if (round_q == NR_L) begin
                  state_d = DONE;
               end else begin
                  round_d = round_q + 4'd1;
                  state_d = ISSUE;
               end
            end else if (timer_q == T_LAST) begin
               state_d = ERR;
            end else begin
               timer_d = timer_q + TW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Registered read port; addresses beyond the last round key read as zero.
   always_comb begin
      rd_data_d = '0;
      if (rk_rd_addr <= NR_L) begin
         rd_data_d = rk_q[rk_rd_addr];
      end
   end

   // State, counters, round-key registers and read data, with synchronous reset.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values, independent of statement order.
      if (reset) begin
         state_q   <= IDLE;
         round_q   <= '0;
         timer_q   <= '0;
         rd_data_q <= '0;
         // NOTE: the key registers are cleared on reset on purpose, so no stale key material survives an abort.
         for (int i = 0; i <= Nr; i++) begin
            rk_q[i] <= '0;
         end
      end else begin
         state_q   <= state_d;
         round_q   <= round_d;
         timer_q   <= timer_d;
         rd_data_q <= rd_data_d;
         rk_q      <= rk_d;
      end
   end

endmodule

// File: tb/tb_key_schedule_ctrl.sv
// Directed bench for key_schedule_ctrl with an AES-128 reference round unit.
`timescale 1ns/1ps

module tb_key_schedule_ctrl;

   localparam logic [127:0] KEY_A  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] RK1_A  = 128'ha0fafe1788542cb123a339392a6c7605;
   localparam logic [127:0] RK10_A = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
   localparam logic [127:0] KEY_B  = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] RK1_B  = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
   localparam logic [127:0] RK10_B = 128'h13111d7fe3944a17f307a78b4d2b30c5;

   logic         clk = 1'b0;
   logic         reset;
   logic         key_valid;
   logic         key_ready;
   logic [127:0] key_in;
   logic         rnd_valid;
   logic [7:0]   rnd_idx;
   logic [127:0] rnd_key;
   logic         rnd_o_valid;
   logic [127:0] rnd_sched;
   logic [3:0]   rk_rd_addr;
   logic [127:0] rk_rd_data;
   logic         sched_done;
   logic         busy;
   logic         err;

   logic         ru_en;
   logic         ru_vld;
   logic [127:0] ru_sched;
   logic         spur;
   logic [127:0] junk;

   int n_total = 0;
   int n_bad   = 0;

   key_schedule_ctrl #(.KEY_LENGTH(128), .Nr(10), .TIMEOUT(8)) dut (
      .clk        (clk),
      .reset      (reset),
      .key_valid  (key_valid),
      .key_ready  (key_ready),
      .key_in     (key_in),
      .rnd_valid  (rnd_valid),
      .rnd_idx    (rnd_idx),
      .rnd_key    (rnd_key),
      .rnd_o_valid(rnd_o_valid),
      .rnd_sched  (rnd_sched),
      .rk_rd_addr (rk_rd_addr),
      .rk_rd_data (rk_rd_data),
      .sched_done (sched_done),
      .busy       (busy),
      .err        (err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%h exp=%h", tag, got, exp);
      end
   endtask

   // {key_ready, busy, sched_done, err, rnd_valid}
   function automatic logic [127:0] flags();
      return 128'({key_ready, busy, sched_done, err, rnd_valid});
   endfunction

   // AES reference round unit (FIPS-197 key expansion, one round per call).
   function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
      logic [7:0] a, b, p;
      a = a_in;
      b = b_in;
      p = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (b[0]) p = p ^ a;
         a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
         b = b >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] sbox(input logic [7:0] x);
      logic [7:0] inv;
      inv = 8'h00;
      if (x != 8'h00) begin
         inv = 8'h01;
         for (int i = 0; i < 254; i++) inv = gmul(inv, x);
      end
      return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
             {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [127:0] expand(input logic [127:0] k, input logic [7:0] r);
      logic [7:0]  rc;
      logic [31:0] rot, t, n0, n1, n2, n3;
      rc = 8'h01;
      for (int i = 1; i < int'(r); i++) rc = rc[7] ? ((rc << 1) ^ 8'h1b) : (rc << 1);
      rot = {k[23:0], k[31:24]};
      t   = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])} ^ {rc, 24'h0};
      n0  = k[127:96] ^ t;
      n1  = k[95:64] ^ n0;
      n2  = k[63:32] ^ n1;
      n3  = k[31:0] ^ n2;
      return {n0, n1, n2, n3};
   endfunction

   // Round unit with one cycle of latency; ru_en=0 models a dead unit.
   always @(posedge clk) begin
      if (reset) ru_vld <= 1'b0;
      else       ru_vld <= ru_en && rnd_valid;
      if (rnd_valid) ru_sched <= expand(rnd_key, rnd_idx);
   end

   assign rnd_o_valid = ru_vld | spur;
   assign rnd_sched   = spur ? junk : ru_sched;

   // Called at a negedge with key_ready high; returns at the first negedge after the handshake edge.
   task automatic start_key(input logic [127:0] k);
      key_in    = k;
      key_valid = 1'b1;
      @(negedge clk);
      key_valid = 1'b0;
   endtask

   // n counts sampling points (negedges) since the handshake edge.
   task automatic wait_done(input int n0, output int n);
      n = n0;
      while (!sched_done && n < 60) begin
         @(negedge clk);
         n++;
      end
   endtask

   task automatic rd(input logic [3:0] a, output logic [127:0] d);
      rk_rd_addr = a;
      @(negedge clk);
      d = rk_rd_data;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int           n;
      logic [127:0] d;

      reset      = 1'b1;
      key_valid  = 1'b0;
      key_in     = '0;
      rk_rd_addr = 4'd0;
      ru_en      = 1'b1;
      spur       = 1'b0;
      junk       = 128'hdeadbeefcafef00d0123456789abcdef;

      // Reset state
      repeat (2) @(negedge clk);
      check("rst_flags", flags(), 128'(5'b10000));
      check("rst_idx", 128'(rnd_idx), 128'h0);
      check("rst_key", rnd_key, 128'h0);
      check("rst_rd", rk_rd_data, 128'h0);
      reset = 1'b0;
      @(negedge clk);

      // FIPS-197 key, full schedule and latency
      start_key(KEY_A);
      check("issue_flags", flags(), 128'(5'b01001));
      check("issue_idx", 128'(rnd_idx), 128'h1);
      check("issue_key", rnd_key, KEY_A);
      @(negedge clk);
      check("wait_flags", flags(), 128'(5'b01000));
      check("wait_key", rnd_key, KEY_A);
      wait_done(2, n);
      check("done_lat_a", 128'(n), 128'(21));
      check("done_flags", flags(), 128'(5'b10100));
      check("done_key", rnd_key, 128'h0);
      check("done_idx", 128'(rnd_idx), 128'h0);
      rd(4'd0, d);  check("rd_0", d, KEY_A);
      rd(4'd1, d);  check("rd_1", d, RK1_A);
      rd(4'd10, d); check("rd_10", d, RK10_A);
      rd(4'd11, d); check("rd_11", d, 128'h0);
      rd(4'd15, d); check("rd_15", d, 128'h0);

      // Second key accepted in DONE
      start_key(KEY_B);
      check("restart_flags", flags(), 128'(5'b01001));
      wait_done(1, n);
      check("done_lat_b", 128'(n), 128'(21));
      rd(4'd0, d);  check("rd_b0", d, KEY_B);
      rd(4'd1, d);  check("rd_b1", d, RK1_B);
      rd(4'd10, d); check("rd_b10", d, RK10_B);

      // Dead round unit: 8 WAIT cycles, then ERR
      ru_en = 1'b0;
      start_key(KEY_A);
      repeat (8) @(negedge clk);
      check("to_last_wait", flags(), 128'(5'b01000));
      @(negedge clk);
      check("to_err_flags", flags(), 128'(5'b10010));
      check("to_err_key", rnd_key, 128'h0);
      rd(4'd1, d);  check("to_rk1_kept", d, RK1_B);
      rd(4'd0, d);  check("to_rk0", d, KEY_A);

      // Reset during round 5 WAIT with a result arriving on the reset cycle
      ru_en = 1'b1;
      start_key(KEY_A);
      n = 1;
      while (!(busy && !rnd_valid && rnd_idx == 8'd5) && n < 60) begin
         @(negedge clk);
         n++;
      end
      check("r5_wait_at", 128'(n), 128'(10));
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("abort_flags", flags(), 128'(5'b10000));
      check("abort_idx", 128'(rnd_idx), 128'h0);
      check("abort_key", rnd_key, 128'h0);
      check("abort_rd", rk_rd_data, 128'h0);
      for (int a = 0; a <= 10; a++) begin
         rd(4'(a), d);
         check($sformatf("abort_rk%0d", a), d, 128'h0);
      end

      // Spurious result pulses in IDLE and in ISSUE
      spur = 1'b1;
      @(negedge clk);
      spur = 1'b0;
      check("spur_idle_flags", flags(), 128'(5'b10000));
      rd(4'd0, d); check("spur_idle_rk0", d, 128'h0);
      start_key(KEY_A);
      spur       = 1'b1;
      rk_rd_addr = 4'd1;
      @(negedge clk);
      spur = 1'b0;
      check("spur_wait_flags", flags(), 128'(5'b01000));
      check("spur_wait_idx", 128'(rnd_idx), 128'h1);
      @(negedge clk);
      check("spur_rk1_untouched", rk_rd_data, 128'h0);
      check("spur_r2_idx", 128'(rnd_idx), 128'h2);
      wait_done(3, n);
      check("done_lat_spur", 128'(n), 128'(21));
      rd(4'd1, d);  check("spur_rd_1", d, RK1_A);
      rd(4'd10, d); check("spur_rd_10", d, RK10_A);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

// File: doc/key_schedule_ctrl.md
KEY_SCHEDULE_CTRL -- requirements
Module: key_schedule_ctrl

Interface
REQ-001 SHALL have parameter KEY_LENGTH, default 128, cipher key and round key width in bits.
REQ-002 SHALL have parameter Nr, default 10, number of expansion rounds.
REQ-003 SHALL have parameter TIMEOUT, default 8, maximum WAIT cycles before error.
REQ-004 SHALL have port clk  input  1  clock; all logic on the rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port key_valid  input  1  new cipher key offered.
REQ-007 SHALL have port key_ready  output  1  controller can accept a key.
REQ-008 SHALL have port key_in  input  KEY_LENGTH  cipher key, word 0 in MSBs.
REQ-009 SHALL have port rnd_valid  output  1  start pulse to the external expansion-round unit.
REQ-010 SHALL have port rnd_idx  output  8  round number (1..Nr) to the round unit.
REQ-011 SHALL have port rnd_key  output  KEY_LENGTH  previous round key to the round unit.
REQ-012 SHALL have port rnd_o_valid  input  1  round unit result valid.
REQ-013 SHALL have port rnd_sched  input  KEY_LENGTH  round unit result (next round key).
REQ-014 SHALL have port rk_rd_addr  input  4  round-key read address.
REQ-015 SHALL have port rk_rd_data  output  KEY_LENGTH  round-key read data.
REQ-016 SHALL have port sched_done  output  1  all Nr+1 round keys valid.
REQ-017 SHALL have port busy  output  1  expansion in progress.
REQ-018 SHALL have port err  output  1  round unit timed out.

Function
REQ-019 SHALL hold Nr+1 round-key registers rk[0..Nr] of KEY_LENGTH bits.
REQ-020 SHALL implement FSM states IDLE, ISSUE, WAIT, DONE, ERR.
REQ-021 SHALL assert key_ready only in IDLE, DONE and ERR; handshake = key_valid & key_ready on a clock edge.
REQ-022 On handshake SHALL load rk[0]=key_in, set round=1, clear sched_done and err, enter ISSUE.
REQ-023 In ISSUE SHALL assert rnd_valid for exactly one cycle with rnd_idx=round, then enter WAIT with timer=0.
REQ-024 In ISSUE and WAIT SHALL drive rnd_key=rk[round-1], held stable; elsewhere rnd_key=0 and rnd_idx=0.
REQ-025 In WAIT, on rnd_o_valid=1 SHALL write rk[round]=rnd_sched; if round==Nr go to DONE, else round+1 and go to ISSUE.
REQ-026 In WAIT with rnd_o_valid=0 SHALL increment timer; when timer reaches TIMEOUT-1 without rnd_o_valid, go to ERR.
REQ-027 SHALL ignore rnd_o_valid in IDLE, ISSUE, DONE and ERR (no register write).
REQ-028 SHALL assert busy in ISSUE and WAIT only; sched_done in DONE only; err in ERR only.
REQ-029 With a round unit of 1-cycle latency, sched_done SHALL rise 2*Nr+1 cycles after the handshake edge (21 for Nr=10).
REQ-030 Key handshake in DONE or ERR SHALL restart the sequence identically to IDLE.
REQ-031 rk_rd_data SHALL be registered, 1-cycle latency: rk[rk_rd_addr] for addr<=Nr, 0 for addr>Nr.
REQ-032 Reads while busy SHALL return current register contents (stale for unfinished rounds); caller gates on sched_done.
REQ-033 round counter SHALL be 4 bits and never exceed Nr.

Reset
REQ-034 On reset SHALL enter IDLE, clear all rk, round, timer; next cycle key_ready=1, all other outputs 0.
REQ-035 Reset mid-sequence SHALL abort immediately; any rnd_o_valid on the reset cycle SHALL be discarded.

Verification
REQ-036 Key 2b7e151628aed2a6abf7158809cf4f3c, reference round unit attached -> rk[1]=a0fafe1788542cb123a339392a6c7605, rk[10]=d014f9a8c9ee2589e13f0cc8b6630ca6, sched_done at handshake+21.
REQ-037 Round unit stubbed with rnd_o_valid stuck 0 -> err=1 after TIMEOUT WAIT cycles, busy=0, key_ready=1, no rk[1] write.
REQ-038 reset asserted during round 5 WAIT -> next cycle all rk=0, key_ready=1, busy=0; new key then completes correctly.
REQ-039 Second key offered in DONE -> sched_done drops next cycle, new schedule completes in 21 cycles, rk[0]=new key.
REQ-040 rk_rd_addr 0, 10, 11, 15 after DONE -> rk_rd_data one cycle later = rk[0], rk[10], 0, 0.
REQ-041 Spurious rnd_o_valid pulse in IDLE and in ISSUE -> no rk change, FSM sequence unaffected.
